conv_window_feeder: RTL
=======================

// Module: conv_window_feeder
// PURPOSE
// Transmit side of the CONV en/D_in/conv_ack interface. Reads a stored RGB feature map from a
// synchronous RAM and streams one KxK window per output position into a CONV layer.
// For each window: conv_en is held high for K*K cycles, then the block waits for conv_ack.
// Sits between a layer's feature-map buffer and its CONV instance, under control of the AlexNet driver.
// PARAMETERS
// IMG_W   27  feature-map width in pixels
// IMG_H   27  feature-map height in pixels
// K       3   kernel side; window = K*K pixels (matches CONV Size)
// STRIDE  1   window step in x and y
// DATA_W  16  pixel width per channel
// ADDR_W  10  RAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
// clk          in   1       clock, rising edge
// rst          in   1       asynchronous reset, active-high
// start        in   1       1-cycle pulse: begin a full sweep of the feature map
// mem_rd_en    out  1       RAM read strobe
// mem_addr     out  ADDR_W  RAM read address, row*IMG_W+col
// mem_rdata_R  in   DATA_W  RAM R data, valid 1 cycle after mem_rd_en
// mem_rdata_G  in   DATA_W  RAM G data, same timing
// mem_rdata_B  in   DATA_W  RAM B data, same timing
// wgt_idx      out  8       kernel tap index 0..K*K-1, aligned with conv_en (weight ROM address)
// conv_en      out  1       window data valid to CONV
// D_in_R       out  DATA_W  pixel R to CONV
// D_in_G       out  DATA_W  pixel G to CONV
// D_in_B       out  DATA_W  pixel B to CONV
// conv_ack     in   1       CONV result-ready pulse for the current window
// busy         out  1       high from the cycle after start until done
// done         out  1       1-cycle pulse after the last window's conv_ack
// BEHAVIOUR
// - Reset (async): all outputs 0; FSM in IDLE; all counters 0.
// - OW=(IMG_W-K)/STRIDE+1, OH=(IMG_H-K)/STRIDE+1. Windows go row-major: ox fastest, then oy.
// - FSM states:
//   - IDLE: on start, go to FETCH with ox=oy=0.
//   - FETCH: exactly K*K cycles. mem_rd_en=1 and mem_addr=(oy*STRIDE+ky)*IMG_W+(ox*STRIDE+kx), kx fastest.
//   - DRAIN: 1 cycle, to present the last tap.
//   - WAIT_ACK: held until conv_ack.
//   - NEXT: 1 cycle; advance ox, or wrap ox to 0 and increment oy; then go to FETCH.
//     If the window just acked was the last (ox=OW-1, oy=OH-1), go to DONE instead.
//   - DONE: done=1 for one cycle, then IDLE.
// - Latency: conv_en, D_in_* and wgt_idx are registered one cycle behind mem_rd_en.
//   Each window gives exactly K*K contiguous conv_en cycles; D_in_* = mem_rdata_*; wgt_idx = 0..K*K-1.
//   conv_en is 0 in every cycle outside those runs.
// - Output registers: D_in_* hold their last value when conv_en=0. wgt_idx returns to 0.
// - Ignored inputs:
//   - start while busy.
//   - conv_ack outside WAIT_ACK (no state change).
// - conv_ack in the same cycle as the DRAIN cycle is not accepted. It must arrive in WAIT_ACK.
// - Reset mid-operation: immediate abort to the reset state; no done pulse.
// - Arithmetic: address math unsigned, width ADDR_W; counters sized by $clog2 of their bound.
// STRUCTURE
// - Shared package (alexnet_pkg): DATA_W, the feeder FSM state enum, and per-layer K/STRIDE/IMG
//   constants, shared with the AlexNet driver.
// - One sub-module, window_addr_gen: holds the ox/oy/kx/ky counters and produces mem_addr and
//   wgt_idx, plus last_tap and last_window flags. FSM and output registers stay in this module.
// TESTING
// 1. IMG 5x5, K=3, STRIDE=1, conv_ack 2 cycles after each window:
//    9 windows, 81 conv_en cycles, done once.
//    Window 0 addresses are 0,1,2,5,6,7,10,11,12.
// 2. Same config with STRIDE=2 -> 4 windows, starting at addrs 0,2,10,12.
//    Window 1 addresses are 2,3,4,7,8,9,12,13,14.
// 3. RAM model returns data=addr: each D_in_R equals the address issued 1 cycle earlier.
//    wgt_idx runs 0..8 in step with conv_en.
// 4. Pulse start during a sweep; pulse conv_ack during FETCH -> neither changes window
//    order, address sequence or counts.
// 5. Assert rst mid-FETCH of window 3 -> conv_en, busy and mem_rd_en are 0 immediately; no done.
//    A new start after reset replays from window 0, address 0.
// 6. conv_ack delayed 50 cycles -> FSM stays in WAIT_ACK, conv_en stays 0, busy stays 1.

Source files
------------

// File: rtl/alexnet_pkg.sv
// rtl/alexnet_pkg.sv - shared pixel width, feeder state encoding and layer geometry
package alexnet_pkg;

  localparam int DATA_W = 16;

  // Geometry of the layer the window feeder serves by default (27x27 map, 3x3 kernel)
  localparam int FEED_IMG_W  = 27;
  localparam int FEED_IMG_H  = 27;
  localparam int FEED_K      = 3;
  localparam int FEED_STRIDE = 1;
  localparam int FEED_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WAIT_ACK,
    ST_NEXT,
    ST_DONE
  } feed_state_t;

  // Number of window positions along one axis
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Counter width for a bound, never narrower than one bit
  function automatic int cnt_w(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - window/tap counters, RAM address and weight tap index
module window_addr_gen import alexnet_pkg::*; #(
  parameter int IMG_W  = FEED_IMG_W,
  parameter int IMG_H  = FEED_IMG_H,
  parameter int K      = FEED_K,
  parameter int STRIDE = FEED_STRIDE,
  parameter int ADDR_W = FEED_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              tap_step,
  input  logic              win_step,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        tap_idx,
  output logic              last_tap,
  output logic              last_window
);

  localparam int OW = out_dim(IMG_W, K, STRIDE);
  localparam int OH = out_dim(IMG_H, K, STRIDE);
  localparam int KW = cnt_w(K);
  localparam int XW = cnt_w(OW);
  localparam int YW = cnt_w(OH);

  localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
  localparam logic [XW-1:0] OX_LAST = XW'(OW - 1);
  localparam logic [YW-1:0] OY_LAST = YW'(OH - 1);

  logic [KW-1:0]     kx, ky;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;
  logic [7:0]        tap;
  logic [ADDR_W-1:0] row, col;

  assign last_tap    = (kx == K_LAST) && (ky == K_LAST);
  assign last_window = (ox == OX_LAST) && (oy == OY_LAST);
  assign tap_idx     = tap;

  // Pixel address of the current tap: row-major, top-left of window plus kernel offset
  assign row  = ADDR_W'(oy) * ADDR_W'(STRIDE) + ADDR_W'(ky);
  assign col  = ADDR_W'(ox) * ADDR_W'(STRIDE) + ADDR_W'(kx);
  assign addr = row * ADDR_W'(IMG_W) + col;

  // Kernel tap walk, kx fastest; wraps back to the window origin after the last tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx  <= '0;
      ky  <= '0;
      tap <= '0;
    end else if (clear) begin
      kx  <= '0;
      ky  <= '0;
      tap <= '0;
    end else if (tap_step) begin
      if (kx == K_LAST) begin
        kx <= '0;
        ky <= (ky == K_LAST) ? '0 : ky + 1'b1;
      end else begin
        kx <= kx + 1'b1;
      end
      tap <= last_tap ? 8'd0 : tap + 8'd1;
    end
  end

  // Output position walk, ox fastest then oy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox <= '0;
      oy <= '0;
    end else if (clear) begin
      ox <= '0;
      oy <= '0;
    end else if (win_step) begin
      if (ox == OX_LAST) begin
        ox <= '0;
        oy <= (oy == OY_LAST) ? '0 : oy + 1'b1;
      end else begin
        ox <= ox + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - streams KxK feature-map windows from RAM into a CONV layer
module conv_window_feeder import alexnet_pkg::*; #(
  parameter int IMG_W  = FEED_IMG_W,
  parameter int IMG_H  = FEED_IMG_H,
  parameter int K      = FEED_K,
  parameter int STRIDE = FEED_STRIDE,
  parameter int DATA_W = alexnet_pkg::DATA_W,
  parameter int ADDR_W = FEED_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata_R,
  input  logic [DATA_W-1:0] mem_rdata_G,
  input  logic [DATA_W-1:0] mem_rdata_B,
  output logic [7:0]        wgt_idx,
  output logic              conv_en,
  output logic [DATA_W-1:0] D_in_R,
  output logic [DATA_W-1:0] D_in_G,
  output logic [DATA_W-1:0] D_in_B,
  input  logic              conv_ack,
  output logic              busy,
  output logic              done
);

  feed_state_t       state, state_next;
  logic              clear, tap_step, win_step;
  logic              last_tap, last_window;
  logic [ADDR_W-1:0] gen_addr;
  logic [7:0]        tap_idx;
  logic [DATA_W-1:0] hold_R, hold_G, hold_B;

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .STRIDE (STRIDE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .tap_step    (tap_step),
    .win_step    (win_step),
    .addr        (gen_addr),
    .tap_idx     (tap_idx),
    .last_tap    (last_tap),
    .last_window (last_window)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and per-state strobes; start and conv_ack are only heard in IDLE / WAIT_ACK
  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    tap_step   = 1'b0;
    win_step   = 1'b0;
    clear      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        tap_step  = 1'b1;
        if (last_tap) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        busy = 1'b1;
        if (conv_ack) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        busy = 1'b1;
        if (last_window) begin
          state_next = ST_DONE;
        end else begin
          win_step   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        clear      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_addr = mem_rd_en ? gen_addr : '0;

  // Window strobe and tap index trail the RAM read by one cycle so they line up with read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_en <= 1'b0;
      wgt_idx <= 8'd0;
    end else begin
      conv_en <= mem_rd_en;
      wgt_idx <= mem_rd_en ? tap_idx : 8'd0;
    end
  end

  // Remember the last delivered pixel so D_in stays stable between window runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_R <= '0;
      hold_G <= '0;
      hold_B <= '0;
    end else if (conv_en) begin
      hold_R <= mem_rdata_R;
      hold_G <= mem_rdata_G;
      hold_B <= mem_rdata_B;
    end
  end

  // Read data is valid in the conv_en cycle itself, so it bypasses straight to the CONV
  assign D_in_R = conv_en ? mem_rdata_R : hold_R;
  assign D_in_G = conv_en ? mem_rdata_G : hold_G;
  assign D_in_B = conv_en ? mem_rdata_B : hold_B;

endmodule
